// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants and the sequencer FSM state encoding.
package alu_pkg;

  localparam logic [5:0] OP_ADD    = 6'b100000;
  localparam logic [5:0] OP_SUB    = 6'b100010;
  localparam logic [5:0] OP_AND    = 6'b100100;
  localparam logic [5:0] OP_OR     = 6'b100101;
  localparam logic [5:0] OP_XOR    = 6'b100110;
  localparam logic [5:0] OP_SRA    = 6'b000011;
  localparam logic [5:0] OP_SRL    = 6'b000010;
  localparam logic [5:0] OP_NOR    = 6'b100111;
  localparam logic [5:0] OP_PASS_A = 6'b000000;
  localparam logic [5:0] OP_PASS_B = 6'b000001;

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    CALC    = 3'd3,
    WAIT_TX = 3'd4
  } state_t;

endpackage

// File: rtl/alu_uart_sequencer_if.sv
// Signal bundle between the ALU sequencer and its UART receiver, transmitter and ALU.
interface alu_uart_sequencer_if #(
  parameter int size = 8
);
  // rx_done_tick and tx_done_tick are single-cycle strobes with no backpressure;
  // tx_start is a one-cycle request, and tx_data holds until tx_done_tick.
  logic            rx_done_tick;
  logic [size-1:0] rx_data;
  logic            tx_done_tick;
  logic [size-1:0] alu_result;
  logic [size-1:0] alu_a;
  logic [size-1:0] alu_b;
  logic [5:0]      alu_op;
  logic            tx_start;
  logic [size-1:0] tx_data;

  modport master (
    input  rx_done_tick, rx_data, tx_done_tick, alu_result,
    output alu_a, alu_b, alu_op, tx_start, tx_data
  );

  modport slave (
    output rx_done_tick, rx_data, tx_done_tick, alu_result,
    input  alu_a, alu_b, alu_op, tx_start, tx_data
  );
endinterface

// File: rtl/alu_uart_sequencer.sv
// Collects A, B and opcode bytes from the UART, latches the ALU result and starts a transmit.
// Optional inter-byte timeout enabled by defining ALU_SEQ_TIMEOUT_EN.
module alu_uart_sequencer
  import alu_pkg::*;
#(
  parameter int size           = 8,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  alu_uart_sequencer_if.master  bus,
  output logic                  busy,
  output state_t                state
);

  state_t state_q, state_d;
  logic   load_a, load_b, load_op;

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q;
  logic             expired;

  assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counts idle cycles between bytes; any accepted byte or return to WAIT_A clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if ((state_q == WAIT_B || state_q == WAIT_OP) && !bus.rx_done_tick && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    load_a  = 1'b0;
    load_b  = 1'b0;
    load_op = 1'b0;
    case (state_q)
      WAIT_A: begin
        if (bus.rx_done_tick) begin
          load_a  = 1'b1;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (bus.rx_done_tick) begin
          load_b  = 1'b1;
          state_d = WAIT_OP;
        end
`ifdef ALU_SEQ_TIMEOUT_EN
        else if (expired) state_d = WAIT_A;
`endif
      end
      WAIT_OP: begin
        if (bus.rx_done_tick) begin
          load_op = 1'b1;
          state_d = CALC;
        end
`ifdef ALU_SEQ_TIMEOUT_EN
        else if (expired) state_d = WAIT_A;
`endif
      end
      CALC:    state_d = WAIT_TX;
      WAIT_TX: if (bus.tx_done_tick) state_d = WAIT_A;
      default: state_d = WAIT_A;
    endcase
  end

  // The ALU settles during CALC; its result is captured only at CALC's closing edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= WAIT_A;
      bus.alu_a    <= '0;
      bus.alu_b    <= '0;
      bus.alu_op   <= 6'b000000;
      bus.tx_data  <= '0;
      bus.tx_start <= 1'b0;
    end else begin
      state_q      <= state_d;
      bus.tx_start <= (state_q == CALC);
      if (load_a)           bus.alu_a   <= bus.rx_data;
      if (load_b)           bus.alu_b   <= bus.rx_data;
      if (load_op)          bus.alu_op  <= bus.rx_data[5:0];
      if (state_q == CALC)  bus.tx_data <= bus.alu_result;
    end
  end

  assign busy  = (state_q != WAIT_A);
  assign state = state_q;

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Self-checking bench for alu_uart_sequencer with a behavioural ALU beside it.
// Exercises the timeout path only when ALU_SEQ_TIMEOUT_EN is defined.
module tb_alu_uart_sequencer;
  import alu_pkg::*;

  localparam int W = 8;

  logic   clk;
  logic   reset;
  logic   busy;
  state_t dbg_state;

  alu_uart_sequencer_if #(.size(W)) bus ();

  alu_uart_sequencer #(.size(W), .TIMEOUT_CYCLES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy),
    .state (dbg_state)
  );

  int n_compared   = 0;
  int n_mismatched = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural ALU ----------------
  function automatic logic [W-1:0] alu_model(logic [W-1:0] a, logic [W-1:0] b, logic [5:0] op);
    logic signed [W-1:0] sa;
    sa = a;
    case (op)
      OP_ADD:    return a + b;
      OP_SUB:    return a - b;
      OP_AND:    return a & b;
      OP_OR:     return a | b;
      OP_XOR:    return a ^ b;
      OP_SRA:    return W'(sa >>> b);
      OP_SRL:    return a >> b;
      OP_NOR:    return ~(a | b);
      OP_PASS_A: return a;
      OP_PASS_B: return b;
      default:   return {W{1'b1}};
    endcase
  endfunction

  always_comb bus.alu_result = alu_model(bus.alu_a, bus.alu_b, bus.alu_op);

  // ---------------- checking ----------------
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every tx_start pulse must match the oldest queued result.
  always @(negedge clk) begin
    if (!reset && bus.tx_start === 1'b1) begin
      if (exp_q.size() == 0) check("tx_spurious", 32'(bus.tx_start), 32'd0);
      else check("tx_data", 32'(bus.tx_data), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- drivers ----------------
  task automatic send_byte(logic [W-1:0] b);
    @(posedge clk); #1;
    bus.rx_done_tick = 1'b1;
    bus.rx_data      = b;
    @(posedge clk); #1;
    bus.rx_done_tick = 1'b0;
    bus.rx_data      = $urandom_range(0, 255);
  endtask

  task automatic pulse_tx_done();
    @(posedge clk); #1;
    bus.tx_done_tick = 1'b1;
    @(posedge clk); #1;
    bus.tx_done_tick = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Full frame with latency checks; leaves the DUT in WAIT_TX unless finish is set.
  task automatic run_frame(logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] op, bit finish);
    logic [W-1:0] exp;
    exp = alu_model(a, b, op[5:0]);
    exp_q.push_back(exp);
    send_byte(a);
    send_byte(b);
    send_byte(op);
    check("alu_op", 32'(bus.alu_op), 32'(op[5:0]));
    check("calc_state", 32'(dbg_state), 32'(CALC));
    check("tx_start_calc", 32'(bus.tx_start), 32'd0);
    @(posedge clk); #1;
    check("tx_start_e1", 32'(bus.tx_start), 32'd1);
    @(posedge clk); #1;
    check("tx_start_e2", 32'(bus.tx_start), 32'd0);
    check("tx_data_hold", 32'(bus.tx_data), 32'(exp));
    check("busy_wait_tx", 32'(busy), 32'd1);
    if (finish) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      pulse_tx_done();
      check("busy_idle", 32'(busy), 32'd0);
      check("operand_a_hold", 32'(bus.alu_a), 32'(a));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    bus.rx_done_tick = 1'b0;
    bus.rx_data      = '0;
    bus.tx_done_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_state", 32'(dbg_state), 32'(WAIT_A));
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_alu_a", 32'(bus.alu_a), 32'd0);
    check("rst_alu_op", 32'(bus.alu_op), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_tx_start", 32'(bus.tx_start), 32'd0);

    run_frame(8'h05, 8'h03, 8'h20, 1'b1);
    run_frame(8'h03, 8'h05, 8'h22, 1'b1);
    run_frame(8'h80, 8'h02, 8'h03, 1'b1);
    run_frame(8'h10, 8'h07, 8'hE0, 1'b1);
    run_frame(8'h12, 8'h34, 8'h3F, 1'b1);

    // Extra byte during WAIT_TX is dropped, then back-to-back frame.
    run_frame(8'h0F, 8'hF0, 8'h25, 1'b0);
    send_byte(8'h11);
    check("drop_rx_alu_a", 32'(bus.alu_a), 32'h0F);
    check("drop_rx_state", 32'(dbg_state), 32'(WAIT_TX));
    pulse_tx_done();
    check("back_idle", 32'(busy), 32'd0);
    send_byte(8'h66);
    check("next_loads_a", 32'(bus.alu_a), 32'h66);
    check("next_busy", 32'(busy), 32'd1);

    // tx_done_tick outside WAIT_TX is ignored.
    pulse_tx_done();
    check("stray_tx_done", 32'(dbg_state), 32'(WAIT_B));
    send_byte(8'h22);
    send_byte(8'h20);
    exp_q.push_back(8'h88);
    repeat (2) @(posedge clk);
    pulse_tx_done();

    // Reset mid-frame discards the partial frame.
    send_byte(8'h05);
    send_byte(8'h03);
    pulse_reset();
    check("mid_rst_state", 32'(dbg_state), 32'(WAIT_A));
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_alu_a", 32'(bus.alu_a), 32'd0);
    check("mid_rst_alu_b", 32'(bus.alu_b), 32'd0);
    check("mid_rst_alu_op", 32'(bus.alu_op), 32'd0);
    check("mid_rst_tx_data", 32'(bus.tx_data), 32'd0);
    run_frame(8'h21, 8'h13, 8'h26, 1'b1);

    // Random frames over the full byte range.
    for (int i = 0; i < 6; i++) begin
      run_frame(W'($urandom_range(0, 255)), W'($urandom_range(0, 7)), W'($urandom_range(0, 255)), 1'b1);
    end

`ifdef ALU_SEQ_TIMEOUT_EN
    send_byte(8'h44);
    repeat (16) @(posedge clk);
    #1;
    check("timeout_state", 32'(dbg_state), 32'(WAIT_A));
    check("timeout_busy", 32'(busy), 32'd0);
    send_byte(8'h55);
    check("timeout_loads_a", 32'(bus.alu_a), 32'h55);
    check("timeout_next_state", 32'(dbg_state), 32'(WAIT_B));
    pulse_reset();
`endif

    repeat (4) @(posedge clk);
    #1;
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/alu_uart_sequencer.md
# alu_uart_sequencer

Byte-serial controller for the ALU in the UART design. Collects operand A, operand B and the opcode as three consecutive bytes from the UART receiver. Drives them into the combinational ALU, latches the result and hands it to the UART transmitter. It is the only block that sequences the ALU; the ALU itself remains purely combinational.

## Interface
- `size`, 8: data width of A, B, result and UART bytes.
- `TIMEOUT_CYCLES`, 50_000_000: inter-byte timeout in clock cycles; used only with the timeout feature.
- `clk` in 1: single system clock; all logic rises on `posedge clk`.
- `reset` in 1: synchronous, active-high reset.
- `rx_done_tick` in 1: one-cycle pulse; `rx_data` is valid this cycle.
- `rx_data` in `size`: received byte.
- `tx_done_tick` in 1: one-cycle pulse; the transmitter has finished its frame.
- `alu_result` in `size`: ALU output (Leds).
- `alu_a` out `size`: registered operand A to the ALU.
- `alu_b` out `size`: registered operand B to the ALU.
- `alu_op` out 6: registered opcode to the ALU.
- `tx_start` out 1: one-cycle start pulse to the transmitter.
- `tx_data` out `size`: registered result byte, stable from `tx_start` until `tx_done_tick`.
- `busy` out 1: high in every state except WAIT_A.

## Operation
- FSM states: WAIT_A, WAIT_B, WAIT_OP, CALC, WAIT_TX.
- WAIT_A + `rx_done_tick` -> load `alu_a` <= `rx_data`, go to WAIT_B.
- WAIT_B + `rx_done_tick` -> load `alu_b` <= `rx_data`, go to WAIT_OP.
- WAIT_OP + `rx_done_tick` -> load `alu_op` <= `rx_data[5:0]`, go to CALC.
  - Opcode bits above bit 5 are discarded silently.
- CALC is always exactly one cycle. At its closing edge:
  - `tx_data` <= `alu_result`.
  - `tx_start` <= 1.
  - Go to WAIT_TX.
- WAIT_TX: `tx_start` clears after one cycle. On `tx_done_tick`, go to WAIT_A.
- `rx_done_tick` during CALC or WAIT_TX is dropped; no byte is buffered.
- `tx_done_tick` outside WAIT_TX is ignored.
- `alu_a`, `alu_b` and `alu_op` hold their values until overwritten by the next frame. The ALU output stays observable after transmission.
- Reset values:
  - State WAIT_A.
  - `alu_a`, `alu_b` = 0.
  - `alu_op` = 6'b000000.
  - `tx_data` = 0, `tx_start` = 0, `busy` = 0.
  - Timeout counter = 0.
- `reset` in any state, including mid-frame or during WAIT_TX, restores all reset values on the next edge. A partially received frame is discarded.

## Timing
- Let the op byte's `rx_done_tick` be sampled at edge E0:
  - `alu_op` is valid after E0.
  - CALC occupies the cycle E0..E1.
  - `tx_data` and `tx_start` are valid after E1.
  - `tx_start` is cleared at E2.
- Total latency from op byte to `tx_start` is 2 edges, independent of opcode.
- The ALU has one full cycle (CALC) of combinational settling. `alu_result` is sampled only at the CALC closing edge.
- Back-to-back frames: a new A byte is accepted on the first `rx_done_tick` after returning to WAIT_A, at earliest the cycle after `tx_done_tick`.

## Configuration
- Macro: `ALU_SEQ_TIMEOUT_EN`.
- Defined:
  - A counter runs in WAIT_B and WAIT_OP and clears on every accepted byte and on entry to WAIT_A.
  - When the count reaches `TIMEOUT_CYCLES`-1 with no `rx_done_tick`, the FSM returns to WAIT_A and the partial frame is discarded. Operand registers are left unchanged.
  - If `rx_done_tick` arrives in the same cycle the count expires, the byte wins and the timeout is ignored.
- Undefined: no counter is synthesized; WAIT_B and WAIT_OP wait indefinitely.

## Structure
- Shared package `alu_pkg`:
  - Opcode constants: ADD 6'b100000, SUB 6'b100010, AND 6'b100100, OR 6'b100101, XOR 6'b100110, SRA 6'b000011, SRL 6'b000010, NOR 6'b100111, PASS_A 6'b000000, PASS_B 6'b000001.
  - FSM state encoding.
- No sub-module. The ALU is instantiated beside the sequencer at the top level, not inside it.

## Test plan
- Bytes 0x05, 0x03, 0x20 -> `alu_op` = 0x20; `tx_data` = 0x08; `tx_start` high for exactly one cycle, 2 edges after the op tick.
- Bytes 0x03, 0x05, 0x22 -> `tx_data` = 0xFE. Bytes 0x80, 0x02, 0x03 (SRA) -> `tx_data` = 0xE0.
- Op byte 0xE0 -> `alu_op` = 0x20 (upper bits masked). Op byte 0x3F -> `tx_data` = 0xFF (ALU default).
- Extra `rx_done_tick` during WAIT_TX with byte 0x11 -> ignored. After `tx_done_tick`, the next byte loads A and `busy` returns low first.
- `reset` pulsed after A = 0x05 and B = 0x03 -> all outputs 0, state WAIT_A. The next three bytes form a fresh frame.
- With `ALU_SEQ_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 16: send A, then idle 16 cycles -> back in WAIT_A with `busy` = 0. The next byte loads A, not B.
